// File: rtl/free_list_ctrl.sv
// Physical-register free list: circular buffer of preg ids with multi-lane
// all-or-nothing allocation, multi-port returns, self-initialisation and a
// sticky overflow flag.
module free_list_ctrl #(
    parameter int unsigned NUM_PREGS   = 64,
    parameter int unsigned NUM_AREGS   = 32,
    parameter int unsigned ALLOC_WIDTH = 2,
    parameter int unsigned FREE_WIDTH  = 2
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic [ALLOC_WIDTH-1:0]                          alloc_req,
    output logic [ALLOC_WIDTH-1:0]                          alloc_grant,
    output logic [ALLOC_WIDTH-1:0][$clog2(NUM_PREGS)-1:0]   alloc_preg,
    output logic                                            rename_stall,
    input  logic [FREE_WIDTH-1:0]                           free_valid,
    input  logic [FREE_WIDTH-1:0][$clog2(NUM_PREGS)-1:0]    free_preg,
    input  logic                                            flush,
    output logic [$clog2(NUM_PREGS):0]                      free_count,
    output logic                                            init_done,
    output logic                                            overflow_err
);

    localparam int unsigned PW        = $clog2(NUM_PREGS);
    localparam int unsigned CW        = PW + 1;
    localparam int unsigned INIT_LAST = NUM_PREGS - NUM_AREGS - 1;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    state_t                          state;
    logic [PW-1:0]                   head;
    logic [PW-1:0]                   tail;
    logic [PW-1:0]                   mem [NUM_PREGS];

    logic [CW-1:0]                   req_cnt;
    logic [CW-1:0]                   grant_cnt;
    logic                            grant_ok;
    logic [ALLOC_WIDTH-1:0][PW-1:0]  lane_addr;

    logic [CW-1:0]                   level;
    logic [CW-1:0]                   accept_cnt;
    logic [FREE_WIDTH-1:0]           free_accept;
    logic [FREE_WIDTH-1:0][PW-1:0]   free_addr;
    logic                            free_drop;

    // Allocation: per-lane read address, all-or-nothing grant decision
    always_comb begin
        req_cnt     = '0;
        lane_addr   = '0;
        alloc_preg  = '0;
        for (int i = 0; i < ALLOC_WIDTH; i++) begin
            lane_addr[i] = head + PW'(req_cnt);
            if (alloc_req[i]) begin
                req_cnt = req_cnt + CW'(1);
            end
        end
        grant_ok     = (state == READY) && !rst && !flush && (req_cnt <= free_count);
        alloc_grant  = grant_ok ? alloc_req : '0;
        grant_cnt    = grant_ok ? req_cnt : '0;
        for (int i = 0; i < ALLOC_WIDTH; i++) begin
            alloc_preg[i] = mem[lane_addr[i]];
        end
        rename_stall = (|alloc_req) && !(|alloc_grant);
    end

    // Returns: accept in port order against the post-grant occupancy
    always_comb begin
        level       = free_count - grant_cnt;
        accept_cnt  = '0;
        free_accept = '0;
        free_addr   = '0;
        free_drop   = 1'b0;
        for (int p = 0; p < FREE_WIDTH; p++) begin
            free_addr[p] = tail + PW'(accept_cnt);
            if (free_valid[p]) begin
                if ((state == READY) && (level < CW'(NUM_PREGS))) begin
                    free_accept[p] = 1'b1;
                    accept_cnt     = accept_cnt + CW'(1);
                    level          = level + CW'(1);
                end else begin
                    free_drop = 1'b1;
                end
            end
        end
    end

    // Buffer storage: seeded during INIT, then written by accepted returns
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[tail] <= PW'(NUM_AREGS) + tail;
        end else begin
            for (int p = 0; p < FREE_WIDTH; p++) begin
                if (free_accept[p]) begin
                    mem[free_addr[p]] <= free_preg[p];
                end
            end
        end
    end

    // Control FSM, pointers, occupancy and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= INIT;
            head         <= '0;
            tail         <= '0;
            free_count   <= '0;
            init_done    <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    tail       <= tail + PW'(1);
                    free_count <= free_count + CW'(1);
                    if (free_drop) begin
                        overflow_err <= 1'b1;
                    end
                    if (tail == PW'(INIT_LAST)) begin
                        state     <= READY;
                        init_done <= 1'b1;
                    end
                end
                READY: begin
                    head       <= head + PW'(grant_cnt);
                    tail       <= tail + PW'(accept_cnt);
                    free_count <= free_count + accept_cnt - grant_cnt;
                    if (free_drop) begin
                        overflow_err <= 1'b1;
                    end
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

endmodule
